// File: rtl/queue_arb_pkg.sv
// ---------------------------------------------------------------------------
// queue_arb_pkg
// Shared constants and the round-robin search helper for the queue read
// arbiter slice.
//   PORT_NUM : number of requesting output schedulers (fixed at 8)
//   ADDR_W   : queue memory address width
//   DATA_W   : queue entry width (next_bufid + TSN tag)
//   PTR_W    : round-robin pointer width
//   rr_first : returns {found, index} of the first set candidate bit,
//              searching circularly upward from the pointer
// ---------------------------------------------------------------------------
package queue_arb_pkg;

  localparam int PORT_NUM = 8;
  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 57;
  localparam int PTR_W    = 3;

  function automatic logic [PTR_W:0] rr_first(input logic [PORT_NUM-1:0] cand,
                                              input logic [PTR_W-1:0]    ptr);
    logic             found;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] index;
    found = 1'b0;
    index = '0;
    idx   = '0;
    // idx wraps naturally at PTR_W bits, giving the circular search
    for (int k = 0; k < PORT_NUM; k++) begin
      idx = ptr + k[PTR_W-1:0];
      if (!found && cand[idx]) begin
        found = 1'b1;
        index = idx;
      end
    end
    return {found, index};
  endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
// Combinational 8-way round-robin pick plus the registered rotate pointer.
// The pointer moves to one past the winner whenever something is granted,
// and holds when no candidate is present.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   cand_i        : candidate request vector
//   grant_vld_o   : a candidate won this cycle
//   grant_idx_o   : index of the winner
//   rr_ptr_o      : current search start point
// ---------------------------------------------------------------------------
module rr_arbiter8
  import queue_arb_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [PORT_NUM-1:0] cand_i,
  output logic                grant_vld_o,
  output logic [PTR_W-1:0]    grant_idx_o,
  output logic [PTR_W-1:0]    rr_ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    {grant_vld_o, grant_idx_o} = rr_first(cand_i, ptr_q);
    ptr_d = ptr_q;
    if (grant_vld_o) begin
      ptr_d = grant_idx_o + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign rr_ptr_o = ptr_q;

endmodule

// File: rtl/queue_read_arbiter.sv
// ---------------------------------------------------------------------------
// queue_read_arbiter
// Shares the single read port of the queue memory between the 8 output
// schedulers. Requests are held in a one-deep pending store per port, one is
// granted per cycle round-robin, and the owning port id travels down a
// latency-matched pipeline so the returned entry can be steered back with a
// one-hot write strobe.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   iv_queue_raddr      : per-port read address, port p at [p*ADDR_W +: ADDR_W]
//   iv_queue_rd         : per-port one-cycle read request
//   ov_ram_raddr        : read address to the queue memory
//   o_ram_rd            : read strobe to the queue memory
//   iv_ram_rdata        : queue memory read data (RAM_LATENCY after o_ram_rd)
//   ov_rd_queue_data    : returned entry, broadcast to all ports
//   ov_rd_queue_data_wr : one-hot strobe marking the owning port
//   ov_req_overflow     : sticky per-port "request while one was pending"
//   ov_rr_ptr           : current round-robin pointer
// ---------------------------------------------------------------------------
module queue_read_arbiter
  import queue_arb_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [PORT_NUM*ADDR_W-1:0] iv_queue_raddr,
  input  logic [PORT_NUM-1:0]        iv_queue_rd,
  output logic [ADDR_W-1:0]          ov_ram_raddr,
  output logic                       o_ram_rd,
  input  logic [DATA_W-1:0]          iv_ram_rdata,
  output logic [DATA_W-1:0]          ov_rd_queue_data,
  output logic [PORT_NUM-1:0]        ov_rd_queue_data_wr,
  output logic [PORT_NUM-1:0]        ov_req_overflow,
  output logic [PTR_W-1:0]           ov_rr_ptr
);

  logic                grantVld;
  logic [PTR_W-1:0]    grantIdx;
  logic [PTR_W-1:0]    rrPtr;
  logic [PORT_NUM-1:0] cand;
  logic [ADDR_W-1:0]   inAddr [PORT_NUM];
  logic [ADDR_W-1:0]   grantAddr;

  logic [PORT_NUM-1:0] pend_q, pend_d;
  logic [PORT_NUM-1:0] ovf_q, ovf_d;
  logic [ADDR_W-1:0]   addr_q [PORT_NUM];
  logic [ADDR_W-1:0]   addr_d [PORT_NUM];

  logic                ramRd_q;
  logic [ADDR_W-1:0]   ramAddr_q;
  logic [PTR_W-1:0]    grantId_q;

  logic [RAM_LATENCY-1:0] pipeVld_q;
  logic [PTR_W-1:0]       pipeId_q [RAM_LATENCY];

  logic [DATA_W-1:0]   rdData_q;
  logic [PORT_NUM-1:0] rdWr_q;

  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      inAddr[p] = iv_queue_raddr[p*ADDR_W +: ADDR_W];
    end
  end

  // A request competes in its own arrival cycle alongside the held ones
  assign cand = pend_q | iv_queue_rd;

  rr_arbiter8 u_rr (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .cand_i      (cand),
    .grant_vld_o (grantVld),
    .grant_idx_o (grantIdx),
    .rr_ptr_o    (rrPtr)
  );

  // A held request is older than anything arriving now, so it is served first
  assign grantAddr = pend_q[grantIdx] ? addr_q[grantIdx] : inAddr[grantIdx];

  // Pending store update. A new request on the granted port re-arms pend so
  // it is served later; on a non-granted port with one already held it
  // replaces the held address and flags overflow.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    addr_d = addr_q;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (iv_queue_rd[p]) begin
        addr_d[p] = inAddr[p];
        if (pend_q[p] && !(grantVld && grantIdx == PTR_W'(p))) begin
          ovf_d[p] = 1'b1;
        end
      end
      if (grantVld && grantIdx == PTR_W'(p)) begin
        pend_d[p] = pend_q[p] & iv_queue_rd[p];
      end else begin
        pend_d[p] = pend_q[p] | iv_queue_rd[p];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= '0;
      ovf_q  <= '0;
      for (int p = 0; p < PORT_NUM; p++) begin
        addr_q[p] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      addr_q <= addr_d;
    end
  end

  // Memory request register; address and id hold when idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ramRd_q   <= 1'b0;
      ramAddr_q <= '0;
      grantId_q <= '0;
    end else begin
      ramRd_q <= grantVld;
      if (grantVld) begin
        ramAddr_q <= grantAddr;
        grantId_q <= grantIdx;
      end
    end
  end

  // Owner tracking. The request register above already marks the cycle the
  // memory sees the read; RAM_LATENCY further stages line the last stage up
  // with the cycle iv_ram_rdata is valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipeVld_q <= '0;
      for (int s = 0; s < RAM_LATENCY; s++) begin
        pipeId_q[s] <= '0;
      end
    end else begin
      pipeVld_q[0] <= ramRd_q;
      pipeId_q[0]  <= grantId_q;
      for (int s = 1; s < RAM_LATENCY; s++) begin
        pipeVld_q[s] <= pipeVld_q[s-1];
        pipeId_q[s]  <= pipeId_q[s-1];
      end
    end
  end

  // Return path: capture data and pulse the owner's strobe for one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdData_q <= '0;
      rdWr_q   <= '0;
    end else begin
      rdWr_q <= '0;
      if (pipeVld_q[RAM_LATENCY-1]) begin
        rdData_q <= iv_ram_rdata;
        rdWr_q[pipeId_q[RAM_LATENCY-1]] <= 1'b1;
      end
    end
  end

  assign ov_ram_raddr        = ramAddr_q;
  assign o_ram_rd            = ramRd_q;
  assign ov_rd_queue_data    = rdData_q;
  assign ov_rd_queue_data_wr = rdWr_q;
  assign ov_req_overflow     = ovf_q;
  assign ov_rr_ptr           = rrPtr;

endmodule

// File: tb/tb_queue_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_queue_read_arbiter
// Directed bench for queue_read_arbiter. Two instances share the request
// inputs: dut1 at RAM_LATENCY=1 and dut3 at RAM_LATENCY=3, each with its own
// memory model. Expected grants are queued as stimulus is driven; a monitor
// pops them against dut1's read strobe and returned data.
// ---------------------------------------------------------------------------
module tb_queue_read_arbiter;
  import queue_arb_pkg::*;

  typedef struct packed {
    logic [PTR_W-1:0]  port;
    logic [ADDR_W-1:0] addr;
  } req_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [PORT_NUM*ADDR_W-1:0] queueRaddr;
  logic [PORT_NUM-1:0]        queueRd;

  logic [ADDR_W-1:0]   ramRaddr1, ramRaddr3;
  logic                ramRd1, ramRd3;
  logic [DATA_W-1:0]   ramRdata1, ramRdata3;
  logic [DATA_W-1:0]   rdData1, rdData3;
  logic [PORT_NUM-1:0] rdWr1, rdWr3;
  logic [PORT_NUM-1:0] ovf1, ovf3;
  logic [PTR_W-1:0]    rrPtr1, rrPtr3;

  int checks = 0;
  int passes = 0;
  req_t grantQ[$];
  req_t retQ[$];
  req_t monEntry;

  localparam logic [DATA_W-1:0] GARBAGE = 57'h0BAD_0BAD_0BAD;

  always #4 clk = ~clk;

  queue_read_arbiter #(.RAM_LATENCY(1)) dut1 (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .iv_queue_raddr      (queueRaddr),
    .iv_queue_rd         (queueRd),
    .ov_ram_raddr        (ramRaddr1),
    .o_ram_rd            (ramRd1),
    .iv_ram_rdata        (ramRdata1),
    .ov_rd_queue_data    (rdData1),
    .ov_rd_queue_data_wr (rdWr1),
    .ov_req_overflow     (ovf1),
    .ov_rr_ptr           (rrPtr1)
  );

  queue_read_arbiter #(.RAM_LATENCY(3)) dut3 (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .iv_queue_raddr      (queueRaddr),
    .iv_queue_rd         (queueRd),
    .ov_ram_raddr        (ramRaddr3),
    .o_ram_rd            (ramRd3),
    .iv_ram_rdata        (ramRdata3),
    .ov_rd_queue_data    (rdData3),
    .ov_rd_queue_data_wr (rdWr3),
    .ov_req_overflow     (ovf3),
    .ov_rr_ptr           (rrPtr3)
  );

  // Memory contents: one pinned entry, every other address self-describing
  function automatic logic [DATA_W-1:0] ramWord(input logic [ADDR_W-1:0] a);
    if (a == 9'h05A) return 57'h1_2345_6789_ABCD;
    return {~a, 39'h12_3456_789A, a};
  endfunction

  // Latency-1 memory: data valid the cycle after the read strobe
  always @(posedge clk) begin
    ramRdata1 <= ramRd1 ? ramWord(ramRaddr1) : GARBAGE;
  end

  // Latency-3 memory: data valid three cycles after the read strobe
  logic              m3v1, m3v2;
  logic [ADDR_W-1:0] m3a1, m3a2;
  always @(posedge clk) begin
    m3v1      <= ramRd3;
    m3a1      <= ramRaddr3;
    m3v2      <= m3v1;
    m3a2      <= m3a1;
    ramRdata3 <= m3v2 ? ramWord(m3a2) : GARBAGE;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard monitor on dut1, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ramRd1) begin
        if (grantQ.size() == 0) begin
          checkOutput("spurious_ram_rd", 64'(ramRd1), 64'd0);
        end else begin
          monEntry = grantQ.pop_front();
          checkOutput("grant_addr", 64'(ramRaddr1), 64'(monEntry.addr));
          retQ.push_back(monEntry);
        end
      end
      if (rdWr1 != '0) begin
        if (retQ.size() == 0) begin
          checkOutput("spurious_strobe", 64'(rdWr1), 64'd0);
        end else begin
          monEntry = retQ.pop_front();
          checkOutput("strobe_owner", 64'(rdWr1), 64'(8'd1 << monEntry.port));
          checkOutput("strobe_data", 64'(rdData1), 64'(ramWord(monEntry.addr)));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setAddr(input int p, input logic [ADDR_W-1:0] a);
    queueRaddr[p*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic expectGrant(input logic [PTR_W-1:0] p, input logic [ADDR_W-1:0] a);
    req_t e;
    e.port = p;
    e.addr = a;
    grantQ.push_back(e);
  endtask

  // Drive one request cycle; returns 1 ns after the edge that samples it
  task automatic applyStimulus(input logic [PORT_NUM-1:0] mask);
    queueRd = mask;
    @(posedge clk);
    #1;
    queueRd = '0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ram_rd1"}, 64'(ramRd1), 64'd0);
    checkOutput({tag, "_raddr1"},  64'(ramRaddr1), 64'd0);
    checkOutput({tag, "_data1"},   64'(rdData1), 64'd0);
    checkOutput({tag, "_wr1"},     64'(rdWr1), 64'd0);
    checkOutput({tag, "_ovf1"},    64'(ovf1), 64'd0);
    checkOutput({tag, "_ptr1"},    64'(rrPtr1), 64'd0);
    checkOutput({tag, "_ram_rd3"}, 64'(ramRd3), 64'd0);
    checkOutput({tag, "_data3"},   64'(rdData3), 64'd0);
    checkOutput({tag, "_wr3"},     64'(rdWr3), 64'd0);
    checkOutput({tag, "_ptr3"},    64'(rrPtr3), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n      = 1'b1;
    queueRd    = '0;
    queueRaddr = '0;
    #2 rst_n = 1'b0;
    idle(2);
    checkReset("reset");
    rst_n = 1'b1;
    idle(2);

    // Single request, port 3, no contention
    $display("[TB] single request");
    setAddr(3, 9'h05A);
    expectGrant(3'd3, 9'h05A);
    applyStimulus(8'b0000_1000);
    checkOutput("single_rd_t1", 64'(ramRd1), 64'd1);
    checkOutput("single_raddr_t1", 64'(ramRaddr1), 64'h05A);
    checkOutput("single_ptr", 64'(rrPtr1), 64'd4);
    idle(1);
    checkOutput("single_rd_t2", 64'(ramRd1), 64'd0);
    checkOutput("single_wr_t2", 64'(rdWr1), 64'd0);
    idle(1);
    checkOutput("single_wr_t3", 64'(rdWr1), 64'h08);
    checkOutput("single_data_t3", 64'(rdData1), 64'h1_2345_6789_ABCD);
    checkOutput("lat3_wr_t3", 64'(rdWr3), 64'd0);
    idle(1);
    checkOutput("single_wr_pulse", 64'(rdWr1), 64'd0);
    checkOutput("single_data_hold", 64'(rdData1), 64'h1_2345_6789_ABCD);
    checkOutput("lat3_wr_t4", 64'(rdWr3), 64'd0);
    idle(1);
    checkOutput("lat3_wr_t5", 64'(rdWr3), 64'h08);
    checkOutput("lat3_data_t5", 64'(rdData3), 64'h1_2345_6789_ABCD);
    idle(2);

    // Pointer back to 0, then all eight ports at once
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    checkOutput("ptr_after_reset", 64'(rrPtr1), 64'd0);
    $display("[TB] all ports");
    for (int p = 0; p < PORT_NUM; p++) begin
      setAddr(p, 9'h100 + 9'(p * 3));
      expectGrant(3'(p), 9'h100 + 9'(p * 3));
    end
    applyStimulus(8'hFF);
    checkOutput("all_ptr_first", 64'(rrPtr1), 64'd1);
    idle(7);
    checkOutput("all_ptr_wrap", 64'(rrPtr1), 64'd0);
    checkOutput("all_no_ovf", 64'(ovf1), 64'd0);
    idle(4);
    checkOutput("all_grants_drained", 64'(grantQ.size()), 64'd0);
    checkOutput("all_returns_drained", 64'(retQ.size()), 64'd0);

    // Move pointer to 5, then ports 2 and 6 contend
    $display("[TB] rotate from 5");
    setAddr(4, 9'h044);
    expectGrant(3'd4, 9'h044);
    applyStimulus(8'b0001_0000);
    checkOutput("rot_ptr5", 64'(rrPtr1), 64'd5);
    idle(3);
    setAddr(2, 9'h022);
    setAddr(6, 9'h066);
    expectGrant(3'd6, 9'h066);
    expectGrant(3'd2, 9'h022);
    applyStimulus(8'b0100_0100);
    checkOutput("rot_ptr7", 64'(rrPtr1), 64'd7);
    idle(1);
    checkOutput("rot_ptr3", 64'(rrPtr1), 64'd3);
    idle(3);

    // Overflow: port 1 held while port 0 wins, new address replaces old
    $display("[TB] overflow");
    setAddr(7, 9'h077);
    setAddr(1, 9'h0BB);
    expectGrant(3'd7, 9'h077);
    expectGrant(3'd0, 9'h0A0);
    expectGrant(3'd1, 9'h111);
    applyStimulus(8'b1000_0010);
    setAddr(0, 9'h0A0);
    setAddr(1, 9'h111);
    applyStimulus(8'b0000_0011);
    checkOutput("ovf_port1", 64'(ovf1), 64'h02);
    idle(1);
    checkOutput("ovf_ptr", 64'(rrPtr1), 64'd2);
    idle(3);

    // Collision: port 4 served from pending while a fresh request arrives
    $display("[TB] collision");
    setAddr(3, 9'h030);
    setAddr(4, 9'h040);
    expectGrant(3'd3, 9'h030);
    expectGrant(3'd4, 9'h040);
    expectGrant(3'd4, 9'h020);
    applyStimulus(8'b0001_1000);
    setAddr(4, 9'h020);
    applyStimulus(8'b0001_0000);
    checkOutput("coll_no_ovf", 64'(ovf1), 64'h02);
    idle(1);
    checkOutput("coll_ptr", 64'(rrPtr1), 64'd5);
    idle(4);
    checkOutput("coll_grants_drained", 64'(grantQ.size()), 64'd0);
    checkOutput("coll_returns_drained", 64'(retQ.size()), 64'd0);

    // Reset one cycle after the read strobe kills the in-flight read
    $display("[TB] reset mid-flight");
    setAddr(5, 9'h155);
    expectGrant(3'd5, 9'h155);
    applyStimulus(8'b0010_0000);
    checkOutput("mid_rd1", 64'(ramRd1), 64'd1);
    checkOutput("mid_rd3", 64'(ramRd3), 64'd1);
    idle(1);
    rst_n = 1'b0;
    #1;
    checkReset("midreset");
    retQ.delete();
    idle(2);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("no_strobe1", 64'(rdWr1), 64'd0);
      checkOutput("no_strobe3", 64'(rdWr3), 64'd0);
    end
    checkOutput("end_grants_drained", 64'(grantQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
